// File: rtl/seg7_scan_driver.sv
// Double-buffered, time-multiplexed 7-segment scanner with BCD/hex decode and digit-switch dead time.
// Optional leading-zero blanking is compiled in when SEG7_LZB_EN is defined.
module seg7_scan_driver #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable_i,
  input  logic                    hex_mode_i,
  input  logic                    load_i,
  input  logic [4*NUM_DIGITS-1:0] data_i,
  input  logic [NUM_DIGITS-1:0]   dp_i,
  output logic [6:0]              seg_anode_o,
  output logic [6:0]              seg_cathode_o,
  output logic                    dp_anode_o,
  output logic                    dp_cathode_o,
  output logic [NUM_DIGITS-1:0]   dig_en_o,
  output logic [NUM_DIGITS-1:0]   dig_en_n_o,
  output logic                    commit_o,
  output logic                    frame_o
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DW    = 4 * NUM_DIGITS;

  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LIM = CNT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] IDX_MAX   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [6:0]       SEG_OFF   = 7'b1111111;

  function automatic logic [6:0] seg_decode(input logic [3:0] nib, input logic hex);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'b0000001;
      4'h1:    seg = 7'b1001111;
      4'h2:    seg = 7'b0010010;
      4'h3:    seg = 7'b0000110;
      4'h4:    seg = 7'b1001100;
      4'h5:    seg = 7'b0100100;
      4'h6:    seg = 7'b1100000;
      4'h7:    seg = 7'b0001111;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0001100;
      4'hA:    seg = hex ? 7'b0001000 : SEG_OFF;
      4'hB:    seg = hex ? 7'b1100000 : SEG_OFF;
      4'hC:    seg = hex ? 7'b0110001 : SEG_OFF;
      4'hD:    seg = hex ? 7'b1000010 : SEG_OFF;
      4'hE:    seg = hex ? 7'b0110000 : SEG_OFF;
      4'hF:    seg = hex ? 7'b0111000 : SEG_OFF;
      default: seg = SEG_OFF;
    endcase
    return seg;
  endfunction

`ifdef SEG7_LZB_EN
  // Blanking runs down from the top digit and stops at the first nonzero nibble or set dp.
  function automatic logic [NUM_DIGITS-1:0] lz_mask(input logic [DW-1:0] nib,
                                                    input logic [NUM_DIGITS-1:0] dp);
    logic                  run;
    logic [NUM_DIGITS-1:0] m;
    run = 1'b1;
    m   = {NUM_DIGITS{1'b0}};
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      run  = run & (nib[4*k +: 4] == 4'h0) & ~dp[k];
      m[k] = run;
    end
    return m;
  endfunction
`endif

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DW-1:0]         sh_nib_q, sh_nib_d;
  logic [NUM_DIGITS-1:0] sh_dp_q, sh_dp_d;
  logic [DW-1:0]         dsp_nib_q, dsp_nib_d;
  logic [NUM_DIGITS-1:0] dsp_dp_q, dsp_dp_d;
  logic                  pending_q, pending_d;
  logic                  commit_q, commit_d;
  logic                  frame_q, frame_d;
  logic                  slot_end_s, frame_end_s, commit_s;

  logic [CNT_W-1:0]      cnt_v_s;
  logic [IDX_W-1:0]      idx_v_s;
  logic [DW-1:0]         dsp_nib_v_s;
  logic [NUM_DIGITS-1:0] dsp_dp_v_s;
  logic [NUM_DIGITS-1:0] lz_blank_s;
  logic [3:0]            nib_sel_s;
  logic                  dp_sel_s;
  logic                  blank_sel_s;
  logic [NUM_DIGITS-1:0] onehot_s;

  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [NUM_DIGITS-1:0] dig_en_q, dig_en_d;

  // Scan counters, double buffer and pulse next-state logic
  always_comb begin
    slot_end_s  = (cnt_q == CNT_MAX);
    frame_end_s = slot_end_s && (idx_q == IDX_MAX);
    commit_s    = frame_end_s && (pending_q || load_i);
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    sh_nib_d    = sh_nib_q;
    sh_dp_d     = sh_dp_q;
    dsp_nib_d   = dsp_nib_q;
    dsp_dp_d    = dsp_dp_q;
    pending_d   = pending_q;

    if (slot_end_s) begin
      cnt_d = {CNT_W{1'b0}};
      if (idx_q == IDX_MAX) begin
        idx_d = {IDX_W{1'b0}};
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    if (load_i) begin
      sh_nib_d = data_i;
      sh_dp_d  = dp_i;
    end else begin
      sh_nib_d = sh_nib_q;
      sh_dp_d  = sh_dp_q;
    end

    // A load in the frame-end cycle bypasses the shadow so it still lands this frame
    if (commit_s) begin
      dsp_nib_d = load_i ? data_i : sh_nib_q;
      dsp_dp_d  = load_i ? dp_i : sh_dp_q;
      pending_d = 1'b0;
    end else if (load_i) begin
      pending_d = 1'b1;
    end else begin
      pending_d = pending_q;
    end

    commit_d = commit_s;
    frame_d  = frame_end_s;
  end

  // State as it will be after this edge; the output registers decode from it
  always_comb begin
    if (rst) begin
      cnt_v_s     = {CNT_W{1'b0}};
      idx_v_s     = {IDX_W{1'b0}};
      dsp_nib_v_s = {DW{1'b0}};
      dsp_dp_v_s  = {NUM_DIGITS{1'b0}};
    end else begin
      cnt_v_s     = cnt_d;
      idx_v_s     = idx_d;
      dsp_nib_v_s = dsp_nib_d;
      dsp_dp_v_s  = dsp_dp_d;
    end
  end

`ifdef SEG7_LZB_EN
  assign lz_blank_s = lz_mask(dsp_nib_v_s, dsp_dp_v_s);
`else
  assign lz_blank_s = {NUM_DIGITS{1'b0}};
`endif

  // Digit select, dead time and segment decode for the upcoming cycle
  always_comb begin
    nib_sel_s   = 4'h0;
    dp_sel_s    = 1'b0;
    blank_sel_s = 1'b0;
    onehot_s    = {NUM_DIGITS{1'b0}};
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_v_s == IDX_W'(k)) begin
        nib_sel_s   = dsp_nib_v_s[4*k +: 4];
        dp_sel_s    = dsp_dp_v_s[k];
        blank_sel_s = lz_blank_s[k];
        onehot_s[k] = 1'b1;
      end else begin
        onehot_s[k] = 1'b0;
      end
    end

    if (!enable_i || (cnt_v_s < BLANK_LIM)) begin
      dig_en_d = {NUM_DIGITS{1'b0}};
      seg_d    = SEG_OFF;
      dp_d     = 1'b1;
    end else begin
      dig_en_d = onehot_s;
      seg_d    = blank_sel_s ? SEG_OFF : seg_decode(nib_sel_s, hex_mode_i);
      dp_d     = ~dp_sel_s;
    end
  end

  // Scan, buffer and pulse registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= {CNT_W{1'b0}};
      idx_q     <= {IDX_W{1'b0}};
      sh_nib_q  <= {DW{1'b0}};
      sh_dp_q   <= {NUM_DIGITS{1'b0}};
      dsp_nib_q <= {DW{1'b0}};
      dsp_dp_q  <= {NUM_DIGITS{1'b0}};
      pending_q <= 1'b0;
      commit_q  <= 1'b0;
      frame_q   <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      sh_nib_q  <= sh_nib_d;
      sh_dp_q   <= sh_dp_d;
      dsp_nib_q <= dsp_nib_d;
      dsp_dp_q  <= dsp_dp_d;
      pending_q <= pending_d;
      commit_q  <= commit_d;
      frame_q   <= frame_d;
    end
  end

  // Display pin registers; their inputs already reflect reset through the view mux
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q    <= seg_d;
      dp_q     <= dp_d;
      dig_en_q <= dig_en_d;
    end else begin
      seg_q    <= seg_d;
      dp_q     <= dp_d;
      dig_en_q <= dig_en_d;
    end
  end

  assign seg_anode_o   = seg_q;
  assign seg_cathode_o = ~seg_q;
  assign dp_anode_o    = dp_q;
  assign dp_cathode_o  = ~dp_q;
  assign dig_en_o      = dig_en_q;
  assign dig_en_n_o    = ~dig_en_q;
  assign commit_o      = commit_q;
  assign frame_o       = frame_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver (4 digits, 8-cycle slots, 2 dead cycles).
module tb_seg7_scan_driver;

  localparam int N  = 4;
  localparam int RD = 8;
  localparam int BC = 2;
`ifdef SEG7_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst, enable_i, hex_mode_i, load_i;
  logic [15:0]  data_i;
  logic [3:0]   dp_i;
  logic [6:0]   seg_anode_o, seg_cathode_o;
  logic         dp_anode_o, dp_cathode_o;
  logic [3:0]   dig_en_o, dig_en_n_o;
  logic         commit_o, frame_o;

  seg7_scan_driver #(.NUM_DIGITS(N), .REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
    .clk(clk), .rst(rst), .enable_i(enable_i), .hex_mode_i(hex_mode_i),
    .load_i(load_i), .data_i(data_i), .dp_i(dp_i),
    .seg_anode_o(seg_anode_o), .seg_cathode_o(seg_cathode_o),
    .dp_anode_o(dp_anode_o), .dp_cathode_o(dp_cathode_o),
    .dig_en_o(dig_en_o), .dig_en_n_o(dig_en_n_o),
    .commit_o(commit_o), .frame_o(frame_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] dig;
    logic [6:0] seg;
    logic       dp;
    logic       commit;
    logic       frame;
  } want_t;

  want_t sb[$];
  int    n_checks = 0;
  int    n_pass   = 0;
  int    cyc_n    = 0;
  int    fr_q[$];

  int          m_cnt, m_idx;
  logic [15:0] m_sh, m_dsp;
  logic [3:0]  m_shdp, m_ddp;
  logic        m_pend, m_commit, m_frame;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_checks++;
    if (obs === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, want, cyc_n);
  endtask

  function automatic logic [6:0] ref_seg(input logic [3:0] v, input logic hex);
    case (v)
      4'd0: return 7'b0000001;  4'd1: return 7'b1001111;
      4'd2: return 7'b0010010;  4'd3: return 7'b0000110;
      4'd4: return 7'b1001100;  4'd5: return 7'b0100100;
      4'd6: return 7'b1100000;  4'd7: return 7'b0001111;
      4'd8: return 7'b0000000;  4'd9: return 7'b0001100;
      4'd10: return hex ? 7'b0001000 : 7'b1111111;
      4'd11: return hex ? 7'b1100000 : 7'b1111111;
      4'd12: return hex ? 7'b0110001 : 7'b1111111;
      4'd13: return hex ? 7'b1000010 : 7'b1111111;
      4'd14: return hex ? 7'b0110000 : 7'b1111111;
      default: return hex ? 7'b0111000 : 7'b1111111;
    endcase
  endfunction

  // Reference model: advance one clock edge using the inputs present at that edge.
  task automatic model_step();
    logic       fe, cm, run;
    logic [3:0] blank;
    want_t      w;
    if (rst) begin
      m_cnt = 0; m_idx = 0; m_sh = 16'h0; m_shdp = 4'h0; m_dsp = 16'h0; m_ddp = 4'h0;
      m_pend = 1'b0; m_commit = 1'b0; m_frame = 1'b0;
    end else begin
      fe = (m_cnt == RD - 1) && (m_idx == N - 1);
      cm = fe && (m_pend || load_i);
      if (cm) begin
        m_dsp = load_i ? data_i : m_sh;
        m_ddp = load_i ? dp_i : m_shdp;
      end
      if (load_i) begin m_sh = data_i; m_shdp = dp_i; end
      if (cm) m_pend = 1'b0;
      else if (load_i) m_pend = 1'b1;
      m_commit = cm;
      m_frame  = fe;
      if (m_cnt == RD - 1) begin
        m_cnt = 0;
        m_idx = (m_idx == N - 1) ? 0 : m_idx + 1;
      end else begin
        m_cnt = m_cnt + 1;
      end
    end
    blank = 4'h0;
    run = 1'b1;
    for (int k = N - 1; k >= 1; k--) begin
      run = run && (m_dsp[4*k +: 4] == 4'h0) && !m_ddp[k];
      blank[k] = LZB && run;
    end
    w.commit = m_commit;
    w.frame  = m_frame;
    if (!enable_i || m_cnt < BC) begin
      w.dig = 4'h0; w.seg = 7'b1111111; w.dp = 1'b1;
    end else begin
      w.dig = 4'b0001 << m_idx;
      w.seg = blank[m_idx] ? 7'b1111111 : ref_seg(m_dsp[4*m_idx +: 4], hex_mode_i);
      w.dp  = ~m_ddp[m_idx];
    end
    sb.push_back(w);
  endtask

  task automatic cyc();
    want_t      w;
    logic [3:0] dn;
    logic [6:0] sc;
    logic       dc;
    @(posedge clk);
    model_step();
    @(negedge clk);
    cyc_n++;
    w  = sb.pop_front();
    dn = ~w.dig;
    sc = ~w.seg;
    dc = ~w.dp;
    chk("dig_en", dig_en_o, w.dig);
    chk("dig_en_n", dig_en_n_o, dn);
    chk("seg_anode", seg_anode_o, w.seg);
    chk("seg_cathode", seg_cathode_o, sc);
    chk("dp_anode", dp_anode_o, w.dp);
    chk("dp_cathode", dp_cathode_o, dc);
    chk("commit", commit_o, w.commit);
    chk("frame", frame_o, w.frame);
    if (frame_o) fr_q.push_back(cyc_n);
  endtask

  task automatic wait_dig(input logic [3:0] tgt);
    int n = 0;
    while (dig_en_o !== tgt && n < 64) begin cyc(); n++; end
    chk("wait_dig", dig_en_o, tgt);
  endtask

  task automatic wait_commit();
    int n = 0;
    while (commit_o !== 1'b1 && n < 80) begin cyc(); n++; end
    chk("wait_commit", commit_o, 1'b1);
  endtask

  task automatic wait_frame();
    int n = 0;
    while (frame_o !== 1'b1 && n < 80) begin cyc(); n++; end
    chk("wait_frame", frame_o, 1'b1);
  endtask

  initial begin
    int z, o, nc, nz;
    rst = 1'b1; enable_i = 1'b1; hex_mode_i = 1'b0; load_i = 1'b0;
    data_i = 16'h0; dp_i = 4'h0;
    cyc(); cyc();
    chk("rst_dig", dig_en_o, 4'b0000);
    chk("rst_seg", seg_anode_o, 7'b1111111);
    rst = 1'b0;

    // First slot: 2 dead cycles then digit 0 for the remaining 6.
    z = (dig_en_o == 4'b0000); o = (dig_en_o == 4'b0001);
    for (int i = 0; i < 7; i++) begin
      cyc();
      z += (dig_en_o == 4'b0000); o += (dig_en_o == 4'b0001);
    end
    chk("slot0_dead", z, 2);
    chk("slot0_dig0", o, 6);
    chk("reset_digit0_zero", seg_anode_o, 7'b0000001);

    fr_q.delete();
    repeat (70) cyc();
    chk("frame_count", fr_q.size(), 2);
    if (fr_q.size() >= 2) chk("frame_period", fr_q[1] - fr_q[0], 32);

    // Double buffer: mid-frame load shows only after the frame-end commit.
    load_i = 1'b1; data_i = 16'h1234; cyc();
    load_i = 1'b0; data_i = 16'hFFFF;
    wait_commit();
    wait_dig(4'b0001); chk("dbuf_d0", seg_anode_o, 7'b1001100);
    wait_dig(4'b1000); chk("dbuf_d3", seg_anode_o, 7'b1001111);

    // Load 1111 early, 2222 exactly in the frame-end cycle.
    wait_frame();
    nc = 0;
    for (int i = 1; i <= 70; i++) begin
      load_i = (i == 5) || (i == 32);
      data_i = (i == 5) ? 16'h1111 : (i == 32) ? 16'h2222 : 16'h5555;
      cyc();
      nc += commit_o;
    end
    load_i = 1'b0;
    chk("one_commit", nc, 1);
    wait_dig(4'b0001); chk("last_wins_d0", seg_anode_o, 7'b0010010);
    wait_dig(4'b1000); chk("last_wins_d3", seg_anode_o, 7'b0010010);

    // Hex decode and its non-hex blanking.
    hex_mode_i = 1'b1; load_i = 1'b1; data_i = 16'hABCD; cyc(); load_i = 1'b0;
    wait_commit();
    wait_dig(4'b0001); chk("hex_d0", seg_anode_o, 7'b1000010);
    wait_dig(4'b1000); chk("hex_d3", seg_anode_o, 7'b0001000);
    hex_mode_i = 1'b0; cyc();
    wait_dig(4'b0001); chk("nohex_d0", seg_anode_o, 7'b1111111);
    wait_dig(4'b1000); chk("nohex_d3", seg_anode_o, 7'b1111111);

    // Display off for 10 cycles.
    enable_i = 1'b0; nz = 0;
    for (int i = 0; i < 10; i++) begin cyc(); nz += (dig_en_o != 4'h0); end
    enable_i = 1'b1;
    chk("disabled_dark", nz, 0);

    // Reset mid-frame drops a pending load.
    load_i = 1'b1; data_i = 16'h7777; cyc(); load_i = 1'b0;
    repeat (3) cyc();
    rst = 1'b1; cyc(); rst = 1'b0;
    chk("midrst_dig", dig_en_o, 4'b0000);
    nc = 0;
    repeat (40) begin cyc(); nc += commit_o; end
    chk("midrst_no_commit", nc, 0);
    wait_dig(4'b0001); chk("midrst_d0", seg_anode_o, 7'b0000001);

    // Leading-zero pattern.
    load_i = 1'b1; data_i = 16'h0040; dp_i = 4'h0; cyc(); load_i = 1'b0;
    wait_commit();
    wait_dig(4'b1000); chk("lz_d3", seg_anode_o, LZB ? 7'b1111111 : 7'b0000001);
    wait_dig(4'b0100); chk("lz_d2", seg_anode_o, LZB ? 7'b1111111 : 7'b0000001);
    wait_dig(4'b0010); chk("lz_d1", seg_anode_o, 7'b1001100);
    wait_dig(4'b0001); chk("lz_d0", seg_anode_o, 7'b0000001);
    load_i = 1'b1; dp_i = 4'b1000; cyc(); load_i = 1'b0;
    wait_commit();
    wait_dig(4'b1000);
    chk("lz_dp_d3", seg_anode_o, 7'b0000001);
    chk("lz_dp_d3_dp", dp_anode_o, 1'b0);
    wait_dig(4'b0100); chk("lz_dp_d2", seg_anode_o, 7'b0000001);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
